// File: rtl/video_timing_gen_if.sv
// Core-side video stream bundle: framebuffer read port plus the timed pixel/sync outputs.
// master = timing generator, slave = the RAM/video-output side.
interface video_timing_gen_if #(
    parameter int DW     = 8,
    parameter int ADDR_W = 17
);
    logic              enable;
    logic              ce_pix;
    logic              fb_rd;
    logic [ADDR_W-1:0] fb_addr;
    logic [DW-1:0]     fb_data;
    logic [DW-1:0]     RGB_out;
    logic              HBlank;
    logic              VBlank;
    logic              HSync;
    logic              VSync;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              frame_start;

    modport master (
        input  enable, fb_data,
        output ce_pix, fb_rd, fb_addr, RGB_out, HBlank, VBlank, HSync, VSync,
               hcount, vcount, frame_start
    );

    modport slave (
        output enable, fb_data,
        input  ce_pix, fb_rd, fb_addr, RGB_out, HBlank, VBlank, HSync, VSync,
               hcount, vcount, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: fetches active pixels from a 1-cycle framebuffer
// and presents RGB/blank/sync one pixel period behind the fetch position.
module video_timing_gen #(
    parameter int DW       = 8,
    parameter int CE_DIV   = 4,
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 40,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 15,
    parameter int ADDR_W   = 17
) (
    input  logic clk_video,
    input  logic reset_n,
    video_timing_gen_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Pixel data needs at least one clock between fetch and the next ce to land in r_pix.
    if (CE_DIV < 2) begin : g_bad_ce_div
        $error("video_timing_gen: CE_DIV must be >= 2");
    end
    if (ADDR_W < $clog2(H_ACTIVE * V_ACTIVE)) begin : g_bad_addr_w
        $error("video_timing_gen: ADDR_W too small for one frame");
    end

    logic [DIV_W-1:0]  r_div;
    logic              r_ce;
    logic              w_ce;
    logic [9:0]        r_h;
    logic [9:0]        r_v;
    logic [ADDR_W-1:0] r_addr;
    logic              w_active;
    logic              w_hLast;
    logic              w_vLast;
    logic              w_rd;
    logic              r_rdq;
    logic [DW-1:0]     r_pix;
    logic [9:0]        r_hPrev;
    logic [9:0]        r_vPrev;
    logic              r_actPrev;
    logic              r_primed;
    logic [DW-1:0]     r_rgb;
    logic              r_hBlank;
    logic              r_vBlank;
    logic              r_hSync;
    logic              r_vSync;
    logic [9:0]        r_hCount;
    logic [9:0]        r_vCount;
    logic              r_frameStart;

    // r_ce holds while frozen, so a pending pixel pulse resumes exactly where it left off.
    assign w_ce = r_ce & vif.enable;

    always_ff @(posedge clk_video) begin
        if (!reset_n) begin
            r_div <= '0;
            r_ce  <= 1'b0;
        end else if (vif.enable) begin
            r_ce  <= (r_div == DIV_LAST);
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign w_active = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign w_hLast  = (r_h == H_LAST_C);
    assign w_vLast  = (r_v == V_LAST_C);
    assign w_rd     = w_ce & w_active;

    always_ff @(posedge clk_video) begin
        if (!reset_n) begin
            r_h    <= '0;
            r_v    <= '0;
            r_addr <= '0;
        end else if (w_ce) begin
            if (w_hLast) begin
                r_h <= '0;
                r_v <= w_vLast ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
            if (w_hLast && w_vLast) begin
                r_addr <= '0;
            end else if (w_active) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_video) begin
        if (!reset_n) begin
            r_rdq <= 1'b0;
            r_pix <= '0;
        end else begin
            r_rdq <= w_rd;
            if (r_rdq) begin
                r_pix <= vif.fb_data;
            end
        end
    end

    // The first ce after reset has no previous position, so outputs keep their reset values.
    always_ff @(posedge clk_video) begin
        if (!reset_n) begin
            r_hPrev      <= '0;
            r_vPrev      <= '0;
            r_actPrev    <= 1'b0;
            r_primed     <= 1'b0;
            r_rgb        <= '0;
            r_hBlank     <= 1'b1;
            r_vBlank     <= 1'b1;
            r_hSync      <= 1'b0;
            r_vSync      <= 1'b0;
            r_hCount     <= '0;
            r_vCount     <= '0;
            r_frameStart <= 1'b0;
        end else if (w_ce) begin
            r_hPrev      <= r_h;
            r_vPrev      <= r_v;
            r_actPrev    <= w_active;
            r_primed     <= 1'b1;
            r_frameStart <= r_primed && (r_hPrev == 10'd0) && (r_vPrev == 10'd0);
            if (r_primed) begin
                r_rgb    <= r_actPrev ? r_pix : '0;
                r_hBlank <= (r_hPrev >= H_ACT_C);
                r_vBlank <= (r_vPrev >= V_ACT_C);
                r_hSync  <= (r_hPrev >= HS_BEG_C) && (r_hPrev < HS_END_C);
                r_vSync  <= (r_vPrev >= VS_BEG_C) && (r_vPrev < VS_END_C);
                r_hCount <= r_hPrev;
                r_vCount <= r_vPrev;
            end
        end else begin
            r_frameStart <= 1'b0;
        end
    end

    assign vif.ce_pix      = w_ce;
    assign vif.fb_rd       = w_rd;
    assign vif.fb_addr     = r_addr;
    assign vif.RGB_out     = r_rgb;
    assign vif.HBlank      = r_hBlank;
    assign vif.VBlank      = r_vBlank;
    assign vif.HSync       = r_hSync;
    assign vif.VSync       = r_vSync;
    assign vif.hcount      = r_hCount;
    assign vif.vcount      = r_vCount;
    assign vif.frame_start = r_frameStart;

endmodule

// File: tb/tb_video_timing_gen.sv
// Runs a CE_DIV=2 and a CE_DIV=4 instance side by side on a tiny 8x6 raster and compares
// every clock against a reference computed from ce counts and raster arithmetic.
module tb_video_timing_gen;

    localparam int H_ACTIVE = 4;
    localparam int H_FP     = 1;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 1;
    localparam int V_ACTIVE = 3;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic clk = 1'b0;
    logic rstn;
    logic en;

    int checks = 0;
    int errors = 0;

    int m [2];
    int nce [2];
    bit fsExp [2];
    bit ceWas [2];
    bit seeded [2];
    int maxAddr [2];

    logic        obsCe [2];
    logic        obsRd [2];
    logic [16:0] obsAddr [2];
    logic [7:0]  obsRgb [2];
    logic        obsHb [2];
    logic        obsVb [2];
    logic        obsHs [2];
    logic        obsVs [2];
    logic [9:0]  obsHc [2];
    logic [9:0]  obsVc [2];
    logic        obsFs [2];

    always #5 clk = ~clk;

    video_timing_gen_if #(.DW(8), .ADDR_W(17)) vifA ();
    video_timing_gen_if #(.DW(8), .ADDR_W(17)) vifB ();

    video_timing_gen #(
        .DW(8), .CE_DIV(2),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .ADDR_W(17)
    ) dutA (.clk_video(clk), .reset_n(rstn), .vif(vifA));

    video_timing_gen #(
        .DW(8), .CE_DIV(4),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .ADDR_W(17)
    ) dutB (.clk_video(clk), .reset_n(rstn), .vif(vifB));

    assign vifA.enable = en;
    assign vifB.enable = en;

    // Framebuffer RAM whose contents equal the address, one clock of read latency.
    always @(posedge clk) begin
        if (vifA.fb_rd) vifA.fb_data <= vifA.fb_addr[7:0];
        if (vifB.fb_rd) vifB.fb_data <= vifB.fb_addr[7:0];
    end

    assign obsCe[0] = vifA.ce_pix;      assign obsCe[1] = vifB.ce_pix;
    assign obsRd[0] = vifA.fb_rd;       assign obsRd[1] = vifB.fb_rd;
    assign obsAddr[0] = vifA.fb_addr;   assign obsAddr[1] = vifB.fb_addr;
    assign obsRgb[0] = vifA.RGB_out;    assign obsRgb[1] = vifB.RGB_out;
    assign obsHb[0] = vifA.HBlank;      assign obsHb[1] = vifB.HBlank;
    assign obsVb[0] = vifA.VBlank;      assign obsVb[1] = vifB.VBlank;
    assign obsHs[0] = vifA.HSync;       assign obsHs[1] = vifB.HSync;
    assign obsVs[0] = vifA.VSync;       assign obsVs[1] = vifB.VSync;
    assign obsHc[0] = vifA.hcount;      assign obsHc[1] = vifB.hcount;
    assign obsVc[0] = vifA.vcount;      assign obsVc[1] = vifB.vcount;
    assign obsFs[0] = vifA.frame_start; assign obsFs[1] = vifB.frame_start;

    function automatic int divOf(int id);
        return (id == 0) ? 2 : 4;
    endfunction

    function automatic int hOf(int n);
        return n % H_TOTAL;
    endfunction

    function automatic int vOf(int n);
        return (n / H_TOTAL) % V_TOTAL;
    endfunction

    function automatic bit actOf(int n);
        return (hOf(n) < H_ACTIVE) && (vOf(n) < V_ACTIVE);
    endfunction

    function automatic int addrOf(int n);
        return vOf(n) * H_ACTIVE + hOf(n);
    endfunction

    task automatic check(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %0h expected %0h", tag, id, obs, exp);
        end
    endtask

    // Reference: the n-th ce since reset fetches raster position n; the outputs shown after
    // that ce describe position n-1, so they trail the ce count by two once primed.
    task automatic checkOutput(input int id);
        bit ce;
        bit rd;
        int p;
        ce = (en === 1'b1) && (m[id] > 0) && ((m[id] % divOf(id)) == 0);
        ceWas[id] = ce;
        if (!seeded[id]) return;
        rd = ce && actOf(nce[id]);
        check("ce_pix", id, obsCe[id], ce);
        check("fb_rd", id, obsRd[id], rd);
        if (rd) check("fb_addr", id, obsAddr[id], addrOf(nce[id]));
        if (obsRd[id] === 1'b1 && obsAddr[id] > maxAddr[id]) maxAddr[id] = obsAddr[id];
        check("frame_start", id, obsFs[id], fsExp[id]);
        if (nce[id] >= 2) begin
            p = nce[id] - 2;
            check("RGB_out", id, obsRgb[id], actOf(p) ? (addrOf(p) & 255) : 0);
            check("HBlank", id, obsHb[id], hOf(p) >= H_ACTIVE);
            check("VBlank", id, obsVb[id], vOf(p) >= V_ACTIVE);
            check("HSync", id, obsHs[id], hOf(p) >= H_ACTIVE + H_FP && hOf(p) < H_ACTIVE + H_FP + H_SYNC);
            check("VSync", id, obsVs[id], vOf(p) >= V_ACTIVE + V_FP && vOf(p) < V_ACTIVE + V_FP + V_SYNC);
            check("hcount", id, obsHc[id], hOf(p));
            check("vcount", id, obsVc[id], vOf(p));
        end else begin
            check("RGB_out_rst", id, obsRgb[id], 0);
            check("HBlank_rst", id, obsHb[id], 1);
            check("VBlank_rst", id, obsVb[id], 1);
            check("HSync_rst", id, obsHs[id], 0);
            check("VSync_rst", id, obsVs[id], 0);
            check("hcount_rst", id, obsHc[id], 0);
            check("vcount_rst", id, obsVc[id], 0);
        end
    endtask

    task automatic updateModel(input int id);
        if (rstn === 1'b0) begin
            m[id] = 0;
            nce[id] = 0;
            fsExp[id] = 1'b0;
            seeded[id] = 1'b1;
        end else begin
            fsExp[id] = 1'b0;
            if (ceWas[id]) begin
                nce[id]++;
                if (nce[id] >= 2) fsExp[id] = (hOf(nce[id] - 2) == 0) && (vOf(nce[id] - 2) == 0);
            end
            if (en === 1'b1) m[id]++;
        end
    endtask

    // One clock: check the cycle's outputs, take the edge, advance the reference.
    task automatic applyStimulus();
        #1;
        for (int id = 0; id < 2; id++) checkOutput(id);
        @(posedge clk);
        for (int id = 0; id < 2; id++) updateModel(id);
        #1;
    endtask

    initial begin
        int fsCount;
        for (int id = 0; id < 2; id++) begin
            m[id] = 0; nce[id] = 0; fsExp[id] = 0; ceWas[id] = 0; seeded[id] = 0; maxAddr[id] = 0;
        end
        rstn = 1'b0;
        en   = 1'b1;
        @(negedge clk);

        $display("[TB] reset hold");
        repeat (5) applyStimulus();
        rstn = 1'b1;

        $display("[TB] two full frames");
        fsCount = 0;
        maxAddr[0] = 0;
        for (int t = 0; t < 2000 && nce[0] < 99; t++) begin
            applyStimulus();
            if (obsFs[0] === 1'b1) fsCount++;
        end
        check("frame_start_count", 0, fsCount, 3);
        check("fb_addr_max", 0, maxAddr[0], 11);

        $display("[TB] freeze mid-line");
        for (int t = 0; t < 200; t++) begin
            if (nce[0] >= 2 && hOf(nce[0] - 2) == 1) break;
            applyStimulus();
        end
        en = 1'b0;
        repeat (7) applyStimulus();
        en = 1'b1;
        repeat (40) applyStimulus();

        $display("[TB] mid-frame reset");
        for (int t = 0; t < 3000; t++) begin
            if (nce[0] >= 2 && hOf(nce[0] - 2) == 2 && vOf(nce[0] - 2) == 2) break;
            applyStimulus();
        end
        rstn = 1'b0;
        repeat (2) applyStimulus();
        rstn = 1'b1;
        for (int t = 0; t < 500; t++) begin
            applyStimulus();
            if (obsFs[0] === 1'b1) break;
        end
        check("ce_to_first_frame_start", 0, nce[0], 2);
        repeat (150) applyStimulus();

        $display("[TB] random enable and reset");
        for (int t = 0; t < 900; t++) begin
            en   = ($urandom_range(0, 3) != 0);
            rstn = ($urandom_range(0, 149) != 0);
            applyStimulus();
        end
        rstn = 1'b1;
        en   = 1'b1;
        repeat (20) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
